// File: rtl/ysyx_22040127_mem_stage_pkg.sv
// Shared definitions for the ysyx_22040127 memory stage: bus widths, memop encodings
// and the execute-to-memory payload layout.
package ysyx_22040127_mem_stage_pkg;

   localparam int EX_TO_MEM_WIDTH = 172;
   localparam int MEM_TO_WB_WIDTH = 103;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   localparam logic [2:0] SB = 3'b000;
   localparam logic [2:0] SH = 3'b001;
   localparam logic [2:0] SW = 3'b010;
   localparam logic [2:0] SD = 3'b011;

   typedef struct packed {
      logic        jalr;
      logic [31:0] pc;
      logic [2:0]  memop;
      logic        reg_wen;
      logic        memwrite;
      logic        memread;
      logic [4:0]  rd;
      logic [63:0] alu_result;
      logic [63:0] wdata;
   } ex_to_mem_t;

endpackage

// File: rtl/ysyx_22040127_load_ext.sv
// Load data extraction: shifts the aligned doubleword down to the access offset and
// sign/zero-extends according to memop.
module ysyx_22040127_load_ext
   import ysyx_22040127_mem_stage_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  off,
   input  logic [2:0]  memop,
   output logic [63:0] data
);

   logic [63:0] shifted;

   assign shifted = rdata >> {off, 3'b000};

   always_comb begin
      case (memop)
         LB:      data = {{56{shifted[7]}}, shifted[7:0]};
         LH:      data = {{48{shifted[15]}}, shifted[15:0]};
         LW:      data = {{32{shifted[31]}}, shifted[31:0]};
         LD:      data = shifted;
         LBU:     data = {56'd0, shifted[7:0]};
         LHU:     data = {48'd0, shifted[15:0]};
         LWU:     data = {32'd0, shifted[31:0]};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_22040127_mem_stage.sv
// Memory stage: holds one instruction, runs its load/store over the req/gnt/rvalid
// data port, and presents the result to writeback until it is accepted.
module ysyx_22040127_mem_stage
   import ysyx_22040127_mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ex_to_mem_valid,
   output logic                       mem_allowin,
   input  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus,
   input  logic                       wb_allowin,
   output logic                       mem_to_wb_valid,
   output logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
   output logic                       dmem_req,
   output logic                       dmem_we,
   output logic [63:0]                dmem_addr,
   output logic [7:0]                 dmem_wmask,
   output logic [63:0]                dmem_wdata,
   input  logic                       dmem_gnt,
   input  logic                       dmem_rvalid,
   input  logic [63:0]                dmem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state, state_nxt;
   ex_to_mem_t  ex_in, r;
   logic        mem_valid, mem_ready_go, latch, access;
   logic [2:0]  off;
   logic [63:0] load_data_r, ext_data;

   assign ex_in        = ex_to_mem_bus;
   assign access       = r.memread | r.memwrite;
   assign off          = r.alu_result[2:0];
   assign mem_ready_go = (state == IDLE && !access) || state == DONE;
   assign mem_allowin  = !mem_valid || (mem_ready_go && wb_allowin);
   assign mem_to_wb_valid = mem_valid && mem_ready_go;
   assign latch        = ex_to_mem_valid && mem_allowin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid <= 1'b0;
         r         <= '0;
      end else begin
         if (mem_allowin) mem_valid <= ex_to_mem_valid;
         if (latch)       r         <= ex_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A latch can only happen from IDLE or DONE, so it always takes priority.
   always_comb begin
      state_nxt = state;
      if (latch) begin
         state_nxt = (ex_in.memread | ex_in.memwrite) ? REQ : IDLE;
      end else begin
         case (state)
            REQ:     if (dmem_gnt)    state_nxt = r.memread ? WAIT : DONE;
            WAIT:    if (dmem_rvalid) state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   ysyx_22040127_load_ext u_load_ext (
      .rdata (dmem_rdata),
      .off   (off),
      .memop (r.memop),
      .data  (ext_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               load_data_r <= '0;
      else if (state == WAIT && dmem_rvalid) load_data_r <= ext_data;
   end

   // Request fields come straight from the stage register, so they are stable while stalled.
   assign dmem_req   = (state == REQ);
   assign dmem_we    = r.memwrite & ~r.memread;
   assign dmem_addr  = {r.alu_result[63:3], 3'b000};
   assign dmem_wdata = r.wdata << {off, 3'b000};

   always_comb begin
      case (r.memop)
         SB:      dmem_wmask = 8'h01 << off;
         SH:      dmem_wmask = 8'h03 << off;
         SW:      dmem_wmask = 8'h0F << off;
         SD:      dmem_wmask = 8'hFF;
         default: dmem_wmask = 8'h00;
      endcase
   end

   assign mem_to_wb_bus = {r.jalr, r.pc, r.reg_wen, r.rd,
                           r.memread ? load_data_r : r.alu_result};

endmodule

// File: tb/tb_ysyx_22040127_mem_stage.sv
// Directed bench for the memory stage with a byte-level reference model and a
// cycle-by-cycle comparison of the writeback and data-memory ports.
module tb_ysyx_22040127_mem_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         ex_to_mem_valid;
   logic         mem_allowin;
   logic [171:0] ex_to_mem_bus;
   logic         wb_allowin;
   logic         mem_to_wb_valid;
   logic [102:0] mem_to_wb_bus;
   logic         dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [63:0]  dmem_addr, dmem_wdata, dmem_rdata;
   logic [7:0]   dmem_wmask;

   always #5 clk = ~clk;

   ysyx_22040127_mem_stage dut (
      .clk(clk), .rst(rst),
      .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
      .ex_to_mem_bus(ex_to_mem_bus), .wb_allowin(wb_allowin),
      .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_bus(mem_to_wb_bus),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
   );

   typedef struct {
      logic        jalr;
      logic [31:0] pc;
      logic [2:0]  memop;
      logic        reg_wen, memwrite, memread;
      logic [4:0]  rd;
      logic [63:0] alu, wdata, rdata;
   } ins_t;

   ins_t        exp_q [0:63];
   int          wr_ptr = 0;
   int          rd_ptr;
   int          nvec = 0, nerr = 0;
   int          gnt_delay = 0, rv_delay = 1;
   logic [63:0] rdata_val = '0;
   int          req_cycles = 0, req_start_last = 0, req_start_prev = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] op);
      return 1 << op[1:0];
   endfunction

   function automatic logic [63:0] m_load(input logic [2:0] op, input logic [2:0] off, input logic [63:0] d);
      logic [63:0] v;
      int n;
      v = '0;
      if (op == 3'b111) return '0;
      n = nbytes(op);
      for (int i = 0; i < n; i++)
         if (int'(off) + i < 8) v[8*i +: 8] = d[8*(int'(off)+i) +: 8];
      if (!op[2] && n < 8 && v[8*n-1])
         for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] m_mask(input logic [2:0] op, input logic [2:0] off);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < nbytes(op); i++)
         if (int'(off) + i < 8) m[int'(off)+i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] m_wdata(input logic [2:0] off, input logic [63:0] d);
      logic [63:0] w;
      w = '0;
      for (int j = int'(off); j < 8; j++) w[8*j +: 8] = d[8*(j-int'(off)) +: 8];
      return w;
   endfunction

   function automatic logic [102:0] m_wb(input ins_t h);
      return {h.jalr, h.pc, h.reg_wen, h.rd,
              h.memread ? m_load(h.memop, h.alu[2:0], h.rdata) : h.alu};
   endfunction

   function automatic ins_t mk(input logic rd_, input logic wr_, input logic [2:0] op,
                               input logic [63:0] alu, input logic [63:0] wd);
      ins_t i;
      i.jalr = alu[4]; i.pc = 32'h8000_0000 + alu[31:0]; i.memop = op;
      i.reg_wen = ~wr_ | rd_; i.memwrite = wr_; i.memread = rd_;
      i.rd = alu[8:4]; i.alu = alu; i.wdata = wd; i.rdata = '0;
      return i;
   endfunction

   // Data memory: grant after gnt_delay waiting cycles, load data rv_delay cycles later.
   initial begin
      int wcnt, rcnt;
      wcnt = 0; rcnt = 0;
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         dmem_gnt = 0; dmem_rvalid = 0;
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin dmem_rvalid = 1; dmem_rdata = rdata_val; end
         end
         if (dmem_req) begin
            if (wcnt >= gnt_delay) begin
               dmem_gnt = 1; wcnt = 0;
               if (!dmem_we) rcnt = rv_delay;
            end else wcnt++;
         end
      end
   end

   // Per-cycle compare against the oldest accepted instruction.
   initial begin
      logic granted, got, acc, done, req_prev, pop, g, rv;
      ins_t h;
      int cyc;
      granted = 0; got = 0; req_prev = 0; rd_ptr = 0; cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         pop = 0; g = 0; rv = 0;
         if (rst) begin
            rd_ptr = wr_ptr; granted = 0; got = 0; req_prev = 0;
         end else begin
            if (dmem_req) begin
               req_cycles++;
               if (!req_prev) begin req_start_prev = req_start_last; req_start_last = cyc; end
            end
            req_prev = dmem_req;
            if (wr_ptr != rd_ptr) begin
               h    = exp_q[rd_ptr % 64];
               acc  = h.memread | h.memwrite;
               done = !acc || (h.memread ? got : granted);
               chk("wb_valid", mem_to_wb_valid, done);
               chk("allowin", mem_allowin, wb_allowin && done);
               chk("dmem_req", dmem_req, acc && !granted);
               if (done && mem_to_wb_valid) chk("wb_bus", mem_to_wb_bus, m_wb(h));
               if (dmem_req && acc && !granted) begin
                  chk("dmem_addr", dmem_addr, {h.alu[63:3], 3'b000});
                  chk("dmem_we", dmem_we, h.memwrite && !h.memread);
                  if (h.memwrite && !h.memread) begin
                     chk("dmem_wmask", dmem_wmask, m_mask(h.memop, h.alu[2:0]));
                     chk("dmem_wdata", dmem_wdata, m_wdata(h.alu[2:0], h.wdata));
                  end
               end
               g   = dmem_req && dmem_gnt;
               rv  = granted && h.memread && dmem_rvalid;
               pop = mem_to_wb_valid && wb_allowin;
            end else begin
               chk("idle_valid", mem_to_wb_valid, 1'b0);
               chk("idle_req", dmem_req, 1'b0);
               chk("idle_allowin", mem_allowin, 1'b1);
            end
            if (pop) begin rd_ptr++; granted = 0; got = 0; end
            else begin granted |= g; got |= rv; end
         end
      end
   end

   task automatic send(input ins_t i);
      int n;
      i.rdata = rdata_val;
      @(posedge clk); #1;
      ex_to_mem_valid = 1;
      ex_to_mem_bus = {i.jalr, i.pc, i.memop, i.reg_wen, i.memwrite, i.memread, i.rd, i.alu, i.wdata};
      n = 0;
      @(negedge clk);
      while (!mem_allowin && n < 50) begin @(negedge clk); n++; end
      if (!mem_allowin) chk("accept_timeout", 0, 1);
      else begin
         @(posedge clk);
         exp_q[wr_ptr % 64] = i;
         wr_ptr++;
      end
      #1 ex_to_mem_valid = 0;
   endtask

   task automatic wait_valid(output int c);
      c = 0;
      @(negedge clk);
      while (!mem_to_wb_valid && c < 40) begin @(negedge clk); c++; end
      if (!mem_to_wb_valid) chk("valid_timeout", 0, 1);
   endtask

   typedef struct { logic [2:0] op; logic [63:0] alu; logic [63:0] exp; } ld_vec_t;

   initial begin
      int c, r0;
      ld_vec_t lv [5];
      rst = 1; ex_to_mem_valid = 0; ex_to_mem_bus = '0; wb_allowin = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", mem_to_wb_valid, 1'b0);
      chk("rst_req", dmem_req, 1'b0);
      chk("rst_allowin", mem_allowin, 1'b1);
      @(posedge clk); #1 rst = 0;

      // ALU passthrough
      send(mk(0, 0, 3'b000, 64'h1234, 64'h0));
      wait_valid(c);
      chk("alu_latency", c, 0);
      chk("alu_wb", mem_to_wb_bus[63:0], 64'h1234);

      // Store byte, grant delayed 3 cycles
      gnt_delay = 3;
      r0 = req_cycles;
      send(mk(0, 1, 3'b000, 64'h8000_0005, 64'hAB));
      wait_valid(c);
      chk("sb_latency", c, 4);
      chk("sb_req_cycles", req_cycles - r0, 4);
      chk("sb_addr", dmem_addr, 64'h8000_0000);
      chk("sb_mask", dmem_wmask, 8'h20);
      chk("sb_lane", dmem_wdata[47:40], 8'hAB);

      // Loads
      gnt_delay = 0; rv_delay = 1;
      rdata_val = 64'h8000_0000_0000_80F0;
      lv[0] = '{3'b000, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0};
      lv[1] = '{3'b100, 64'h100, 64'h0000_0000_0000_00F0};
      lv[2] = '{3'b001, 64'h100, 64'hFFFF_FFFF_FFFF_80F0};
      lv[3] = '{3'b110, 64'h104, 64'h0000_0000_8000_0000};
      lv[4] = '{3'b011, 64'h100, 64'h8000_0000_0000_80F0};
      foreach (lv[k]) begin
         send(mk(1, 0, lv[k].op, lv[k].alu, 64'h0));
         wait_valid(c);
         chk("load_latency", c, 2);
         chk("load_data", mem_to_wb_bus[63:0], lv[k].exp);
      end
      // memread and memwrite together behave as a load
      send(mk(1, 1, 3'b011, 64'h108, 64'h5A5A));
      wait_valid(c);
      chk("rdwr_load_data", mem_to_wb_bus[63:0], 64'h8000_0000_0000_80F0);

      // Backpressure: result held, no re-issue, upstream kept out
      @(posedge clk); #1 wb_allowin = 0;
      send(mk(1, 0, 3'b010, 64'h200, 64'h0));
      wait_valid(c);
      r0 = req_cycles;
      @(posedge clk); #1;
      ex_to_mem_valid = 1;
      ex_to_mem_bus = '1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", mem_to_wb_valid, 1'b1);
         chk("bp_data", mem_to_wb_bus[63:0], 64'h80F0);
         chk("bp_allowin", mem_allowin, 1'b0);
      end
      chk("bp_no_reissue", req_cycles - r0, 0);
      @(posedge clk); #1 ex_to_mem_valid = 0; wb_allowin = 1;
      send(mk(0, 0, 3'b000, 64'h5555, 64'h0));
      wait_valid(c);
      chk("bp_next_wb", mem_to_wb_bus[63:0], 64'h5555);

      // Misaligned word store truncated to the doubleword
      send(mk(0, 1, 3'b010, 64'h406, 64'hDEAD_BEEF));
      wait_valid(c);
      chk("sw_trunc_mask", dmem_wmask, 8'hC0);
      chk("sw_trunc_data", dmem_wdata, 64'hBEEF_0000_0000_0000);

      // Back-to-back stores
      send(mk(0, 1, 3'b011, 64'h300, 64'h1111_2222_3333_4444));
      send(mk(0, 1, 3'b001, 64'h30A, 64'hBEEF));
      wait_valid(c);
      chk("b2b_latency", c, 1);
      chk("b2b_spacing", req_start_last - req_start_prev, 2);
      chk("sh_mask", dmem_wmask, 8'h0C);
      chk("sh_data", dmem_wdata, 64'hBEEF_0000);

      // Reset while waiting for load data, then a stray rvalid
      rv_delay = 8;
      send(mk(1, 0, 3'b000, 64'h500, 64'h0));
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      chk("rst_mid_valid", mem_to_wb_valid, 1'b0);
      chk("rst_mid_allowin", mem_allowin, 1'b1);
      @(posedge clk); #1 rst = 0;
      repeat (10) begin
         @(negedge clk);
         chk("stray_valid", mem_to_wb_valid, 1'b0);
         chk("stray_req", dmem_req, 1'b0);
      end
      chk("stray_allowin", mem_allowin, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
